bpi_cmd_seq: RTL and testbench
==============================

// Module: bpi_cmd_seq
// PURPOSE
//  Command sequencer sitting directly upstream of the BPI interface FSM. Accepts one flash command
//  (read/write/program/erase/unlock) via valid/ready, expands it into the required series of
//  single bus cycles, and drives EXECUTE/READ/WRITE plus address/data to the interface FSM.
//  Collects read data on LOAD, polls the status register for program/erase, and reports DONE/ERR.
// PARAMETERS
//  ADDR_W     23     flash word-address width
//  DATA_W     16     flash data width
//  POLL_MAX   65535  max status reads before timeout error
//  BUSY_TO    4      cycles allowed for BUSY to rise after EXECUTE
// PORTS
//  CLK        in   1       system clock; all logic on rising edge
//  RST_N      in   1       asynchronous, active-low reset
//  CMD_VLD    in   1       command valid
//  CMD_RDY    out  1       sequencer idle and able to accept
//  CMD_OP     in   3       opcode: 0 READ, 1 WRITE, 2 PROG, 3 ERASE, 4 UNLOCK, 5-7 illegal
//  CMD_ADDR   in   ADDR_W  target word address
//  CMD_DATA   in   DATA_W  write/program data
//  RD_DATA    out  DATA_W  data from last OP_READ; held until next read
//  RD_VLD     out  1       1-cycle pulse when RD_DATA updates
//  STATUS     out  DATA_W  last status-register word read during polling
//  DONE       out  1       1-cycle pulse at command completion
//  ERR        out  1       valid with DONE: illegal op, BUSY timeout, poll timeout, or SR error
//  EXECUTE    out  1       1-cycle start pulse to interface FSM
//  READ       out  1       read request; stable from EXECUTE until BUSY falls
//  WRITE      out  1       write request; stable from EXECUTE until BUSY falls
//  BUS_ADDR   out  ADDR_W  address for current bus cycle; stable while cycle active
//  BUS_DOUT   out  DATA_W  write data for current bus cycle; stable while cycle active
//  BUSY       in   1       interface FSM busy
//  LOAD       in   1       interface FSM read-data strobe
//  BUS_DIN    in   DATA_W  read data, valid when LOAD=1
// BEHAVIOUR
//  Reset: every output 0 except CMD_RDY=1; FSM to IDLE. Async reset mid-command aborts it: no DONE.
//  Accept: CMD_VLD&&CMD_RDY registers OP/ADDR/DATA; CMD_RDY falls the next cycle, rises with DONE.
//  Step lists (W=write cycle, R=read cycle, all at CMD_ADDR):
//   READ: R -> RD_DATA, RD_VLD.  WRITE: W(data).  UNLOCK: W(0x0060), W(0x00D0).
//   PROG: W(0x0040), W(data), W(0x0070), POLL, W(0x00FF).
//   ERASE: W(0x0020), W(0x00D0), W(0x0070), POLL, W(0x00FF).
//   POLL: repeat R until BUS_DIN[7]=1; each LOAD updates STATUS. On exit ERR |= |(STATUS & 0x003A).
//  Illegal op: DONE=1,ERR=1 the cycle after accept; no bus cycles.
//  States: IDLE, DECODE, ISSUE, WAIT_HI, WAIT_LO, STEP, FINISH.
//   IDLE: CMD_RDY=1; accept -> DECODE.  DECODE: load step 0 (or FINISH w/ERR if illegal).
//   ISSUE: EXECUTE=1 one cycle; READ/WRITE/BUS_* set -> WAIT_HI.
//   WAIT_HI: BUSY=1 -> WAIT_LO; BUSY_TO cycles without BUSY -> FINISH, ERR=1.
//   WAIT_LO: capture BUS_DIN on LOAD; BUSY=0 -> drop READ/WRITE, -> STEP.
//   STEP: poll not ready and count<POLL_MAX -> ISSUE (same R); count=POLL_MAX -> FINISH, ERR=1,
//    the 0x00FF restore write is skipped; else next step -> ISSUE, or FINISH if list exhausted.
//   FINISH: DONE=1 one cycle -> IDLE.
//  READ and WRITE never both 1. EXECUTE never asserted while BUSY=1.
//  LOAD outside WAIT_LO is ignored. Poll counter 16 bit, saturates, cleared in DECODE.
//  Per-cycle latency: 1 cycle after ISSUE to BUSY=1; one READ command ~11 cycles accept-to-DONE.
// STRUCTURE
//  Package bpi_pkg: opcode constants, flash command words (0x0040,0x0020,0x00D0,0x0060,0x0070,
//   0x00FF), SR masks (READY=0x0080, ERR=0x003A), state encoding.
//  Sub-module bpi_step_rom: combinational (op, step index) -> {is_read, is_poll, data_sel, last}.
//  Top holds FSM, counters, registers; interface FSM instantiated by parent, not here.
// TESTING
//  Bench pairs DUT with a behavioural model of the interface FSM (BUSY one cycle after EXECUTE).
//  1. Reset then OP_READ addr 0x000123, model returns 0xBEEF -> one R cycle, RD_VLD pulse,
//     RD_DATA=0xBEEF, DONE=1 ERR=0, READ=1 WRITE=0 throughout.
//  2. OP_PROG addr 0x001000 data 0x5A5A, SR 0x0000 x3 then 0x0080 -> W 0x0040, W 0x5A5A, W 0x0070,
//     4 R, W 0x00FF; STATUS=0x0080; DONE ERR=0.
//  3. OP_ERASE with final SR 0x00A0 -> full sequence incl. 0x00FF, STATUS=0x00A0, DONE with ERR=1.
//  4. POLL_MAX=3, SR stuck 0x0000 -> exactly 3 poll reads, no 0x00FF write, DONE ERR=1.
//  5. Model never raises BUSY -> DONE ERR=1 after BUSY_TO cycles in WAIT_HI; CMD_OP=6 -> immediate
//     DONE ERR=1, EXECUTE never pulses.
//  6. RST_N low during WAIT_LO of a PROG -> outputs 0, CMD_RDY=1 at once, no DONE; next READ works.

Source files
------------

// File: rtl/bpi_pkg.sv
// ---------------------------------------------------------------------------
// bpi_pkg
// Shared definitions for the BPI command sequencer: opcode values, the flash
// command words written during multi-cycle sequences, status-register masks,
// the per-step data selector and the sequencer state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package bpi_pkg;

    // Command opcodes; 5..7 are illegal
    localparam logic [2:0] OP_READ   = 3'd0;
    localparam logic [2:0] OP_WRITE  = 3'd1;
    localparam logic [2:0] OP_PROG   = 3'd2;
    localparam logic [2:0] OP_ERASE  = 3'd3;
    localparam logic [2:0] OP_UNLOCK = 3'd4;

    // Flash command words
    localparam logic [15:0] FW_PROG_SETUP   = 16'h0040;
    localparam logic [15:0] FW_ERASE_SETUP  = 16'h0020;
    localparam logic [15:0] FW_CONFIRM      = 16'h00D0;
    localparam logic [15:0] FW_UNLOCK_SETUP = 16'h0060;
    localparam logic [15:0] FW_READ_SR      = 16'h0070;
    localparam logic [15:0] FW_READ_ARRAY   = 16'h00FF;

    // Status register masks
    localparam logic [15:0] SR_READY = 16'h0080;
    localparam logic [15:0] SR_ERR   = 16'h003A;

    // What a write step puts on the data bus
    typedef enum logic [2:0] {
        SEL_CMD_DATA,
        SEL_PROG_SETUP,
        SEL_ERASE_SETUP,
        SEL_CONFIRM,
        SEL_UNLOCK_SETUP,
        SEL_READ_SR,
        SEL_READ_ARRAY
    } data_sel_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_ISSUE,
        ST_WAIT_HI,
        ST_WAIT_LO,
        ST_STEP,
        ST_FINISH
    } state_e;

    function automatic logic op_is_legal(input logic [2:0] op);
        return op <= OP_UNLOCK;
    endfunction

    // Fixed flash command word for a selector; SEL_CMD_DATA is muxed by the caller
    function automatic logic [15:0] sel_word(input data_sel_e sel);
        logic [15:0] w;
        case (sel)
            SEL_PROG_SETUP:   w = FW_PROG_SETUP;
            SEL_ERASE_SETUP:  w = FW_ERASE_SETUP;
            SEL_CONFIRM:      w = FW_CONFIRM;
            SEL_UNLOCK_SETUP: w = FW_UNLOCK_SETUP;
            SEL_READ_SR:      w = FW_READ_SR;
            SEL_READ_ARRAY:   w = FW_READ_ARRAY;
            default:          w = 16'h0000;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/bpi_step_rom.sv
// ---------------------------------------------------------------------------
// bpi_step_rom
// Combinational step table: for a legal opcode and step index, tells the
// sequencer whether the bus cycle is a read, whether it is the status poll,
// which data word a write carries, and whether it is the last step.
//   op_i       in  3  opcode of the command in progress
//   step_i     in  3  step index within the command's list
//   is_read_o  out 1  step is a read cycle (otherwise a write)
//   is_poll_o  out 1  step is the status-register poll read
//   data_sel_o out    selector for the write data word
//   last_o     out 1  no further steps follow this one
// ---------------------------------------------------------------------------
module bpi_step_rom
    import bpi_pkg::*;
(
    input  logic [2:0] op_i,
    input  logic [2:0] step_i,
    output logic       is_read_o,
    output logic       is_poll_o,
    output data_sel_e  data_sel_o,
    output logic       last_o
);

    always_comb begin
        is_read_o  = 1'b0;
        is_poll_o  = 1'b0;
        data_sel_o = SEL_CMD_DATA;
        last_o     = 1'b1;
        case (op_i)
            OP_READ: begin
                is_read_o = 1'b1;
            end
            OP_UNLOCK: begin
                if (step_i == 3'd0) begin
                    data_sel_o = SEL_UNLOCK_SETUP;
                    last_o     = 1'b0;
                end else begin
                    data_sel_o = SEL_CONFIRM;
                end
            end
            // PROG and ERASE share the read-SR / poll / read-array tail
            OP_PROG, OP_ERASE: begin
                last_o = 1'b0;
                case (step_i)
                    3'd0: data_sel_o = (op_i == OP_PROG) ? SEL_PROG_SETUP : SEL_ERASE_SETUP;
                    3'd1: data_sel_o = (op_i == OP_PROG) ? SEL_CMD_DATA : SEL_CONFIRM;
                    3'd2: data_sel_o = SEL_READ_SR;
                    3'd3: begin
                        is_read_o = 1'b1;
                        is_poll_o = 1'b1;
                    end
                    default: begin
                        data_sel_o = SEL_READ_ARRAY;
                        last_o     = 1'b1;
                    end
                endcase
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/bpi_cmd_seq.sv
// ---------------------------------------------------------------------------
// bpi_cmd_seq
// Accepts one flash command over valid/ready and expands it into single bus
// cycles for the downstream BPI interface FSM, polling the status register
// for program/erase, and reports completion with DONE/ERR.
//   clk_i, rst_ni               clock, async active-low reset
//   cmd_vld_i/cmd_rdy_o         command handshake
//   cmd_op_i/addr_i/data_i      opcode, word address, write/program data
//   rd_data_o/rd_vld_o          data of the last READ and its update pulse
//   status_o                    last status word read while polling
//   done_o/err_o                completion pulse and its error flag
//   execute_o/read_o/write_o    bus-cycle request to the interface FSM
//   bus_addr_o/bus_dout_o       address and write data of the current cycle
//   busy_i/load_i/bus_din_i     interface FSM busy, read strobe, read data
// ---------------------------------------------------------------------------
module bpi_cmd_seq
    import bpi_pkg::*;
#(
    parameter int ADDR_W   = 23,
    parameter int DATA_W   = 16,
    parameter int POLL_MAX = 65535,
    parameter int BUSY_TO  = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cmd_vld_i,
    output logic              cmd_rdy_o,
    input  logic [2:0]        cmd_op_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [DATA_W-1:0] cmd_data_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_vld_o,
    output logic [DATA_W-1:0] status_o,
    output logic              done_o,
    output logic              err_o,
    output logic              execute_o,
    output logic              read_o,
    output logic              write_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_dout_o,
    input  logic              busy_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] bus_din_i
);

    localparam int TO_W = $clog2(BUSY_TO + 1);

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [2:0]        step_q, step_d;
    logic [15:0]       poll_cnt_q, poll_cnt_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_vld_q, rd_vld_d;
    logic [DATA_W-1:0] status_q, status_d;

    logic              rom_is_read, rom_is_poll, rom_last;
    data_sel_e         rom_sel;
    logic [DATA_W-1:0] step_word;
    logic [15:0]       poll_inc;
    logic              in_cycle, accept;

    bpi_step_rom u_rom (
        .op_i       (op_q),
        .step_i     (step_q),
        .is_read_o  (rom_is_read),
        .is_poll_o  (rom_is_poll),
        .data_sel_o (rom_sel),
        .last_o     (rom_last)
    );

    assign step_word = (rom_sel == SEL_CMD_DATA) ? data_q : DATA_W'(sel_word(rom_sel));
    assign poll_inc  = (poll_cnt_q == 16'hFFFF) ? poll_cnt_q : poll_cnt_q + 16'd1;

    // A new command may be taken in the DONE cycle so back-to-back commands lose no cycle
    assign cmd_rdy_o = (state_q == ST_IDLE) || (state_q == ST_FINISH);
    assign accept    = cmd_vld_i && cmd_rdy_o;

    // Bus request decoded from the registered step, so it holds from EXECUTE until BUSY falls
    assign in_cycle   = (state_q == ST_ISSUE) || (state_q == ST_WAIT_HI) || (state_q == ST_WAIT_LO);
    assign execute_o  = (state_q == ST_ISSUE);
    assign read_o     = in_cycle && rom_is_read;
    assign write_o    = in_cycle && !rom_is_read;
    assign bus_addr_o = in_cycle ? addr_q : '0;
    assign bus_dout_o = write_o ? step_word : '0;

    assign done_o    = (state_q == ST_FINISH);
    assign err_o     = done_o && err_q;
    assign rd_data_o = rd_data_q;
    assign rd_vld_o  = rd_vld_q;
    assign status_o  = status_q;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        data_d     = data_q;
        step_d     = step_q;
        poll_cnt_d = poll_cnt_q;
        to_cnt_d   = to_cnt_q;
        err_d      = err_q;
        rd_data_d  = rd_data_q;
        rd_vld_d   = 1'b0;
        status_d   = status_q;

        case (state_q)
            ST_DECODE: begin
                step_d     = 3'd0;
                poll_cnt_d = 16'd0;
                state_d    = ST_ISSUE;
            end
            ST_ISSUE: begin
                to_cnt_d = '0;
                state_d  = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                if (busy_i) begin
                    state_d = ST_WAIT_LO;
                end else if (to_cnt_q == TO_W'(BUSY_TO - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_FINISH;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            ST_WAIT_LO: begin
                if (load_i && rom_is_read) begin
                    if (rom_is_poll) begin
                        status_d = bus_din_i;
                    end else begin
                        rd_data_d = bus_din_i;
                        rd_vld_d  = 1'b1;
                    end
                end
                if (!busy_i) begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                if (rom_is_poll && !status_q[7]) begin
                    // Device still busy: reissue the same poll read until the budget runs out
                    poll_cnt_d = poll_inc;
                    if (poll_inc >= 16'(POLL_MAX)) begin
                        err_d   = 1'b1;
                        state_d = ST_FINISH;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end else begin
                    if (rom_is_poll) begin
                        poll_cnt_d = poll_inc;
                        err_d      = err_q | (|(status_q & DATA_W'(SR_ERR)));
                    end
                    if (rom_last) begin
                        state_d = ST_FINISH;
                    end else begin
                        step_d  = step_q + 3'd1;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Illegal opcodes go straight to FINISH so DONE/ERR appear the cycle after accept
        if (accept) begin
            op_d    = cmd_op_i;
            addr_d  = cmd_addr_i;
            data_d  = cmd_data_i;
            err_d   = !op_is_legal(cmd_op_i);
            state_d = op_is_legal(cmd_op_i) ? ST_DECODE : ST_FINISH;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            step_q     <= '0;
            poll_cnt_q <= '0;
            to_cnt_q   <= '0;
            err_q      <= 1'b0;
            rd_data_q  <= '0;
            rd_vld_q   <= 1'b0;
            status_q   <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            step_q     <= step_d;
            poll_cnt_q <= poll_cnt_d;
            to_cnt_q   <= to_cnt_d;
            err_q      <= err_d;
            rd_data_q  <= rd_data_d;
            rd_vld_q   <= rd_vld_d;
            status_q   <= status_d;
        end
    end

endmodule

// File: tb/tb_bpi_cmd_seq.sv
// ---------------------------------------------------------------------------
// tb_bpi_cmd_seq
// Drives bpi_cmd_seq with directed and random commands against a behavioural
// interface-FSM model; expected bus-cycle lists and results come from the
// command step rules computed here.
// ---------------------------------------------------------------------------
module tb_bpi_cmd_seq;

    localparam int ADDR_W   = 23;
    localparam int DATA_W   = 16;
    localparam int POLL_MAX = 6;
    localparam int BUSY_TO  = 4;

    localparam logic [2:0] OP_READ   = 3'd0;
    localparam logic [2:0] OP_WRITE  = 3'd1;
    localparam logic [2:0] OP_PROG   = 3'd2;
    localparam logic [2:0] OP_ERASE  = 3'd3;
    localparam logic [2:0] OP_UNLOCK = 3'd4;

    logic              clk;
    logic              rstN;
    logic              cmdVld;
    logic              cmdRdy;
    logic [2:0]        cmdOp;
    logic [ADDR_W-1:0] cmdAddr;
    logic [DATA_W-1:0] cmdData;
    logic [DATA_W-1:0] rdData;
    logic              rdVld;
    logic [DATA_W-1:0] status;
    logic              done;
    logic              err;
    logic              execute;
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] busAddr;
    logic [DATA_W-1:0] busDout;
    logic              busy;
    logic              load;
    logic [DATA_W-1:0] busDin;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bpi_cmd_seq #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .POLL_MAX (POLL_MAX),
        .BUSY_TO  (BUSY_TO)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rstN),
        .cmd_vld_i  (cmdVld),
        .cmd_rdy_o  (cmdRdy),
        .cmd_op_i   (cmdOp),
        .cmd_addr_i (cmdAddr),
        .cmd_data_i (cmdData),
        .rd_data_o  (rdData),
        .rd_vld_o   (rdVld),
        .status_o   (status),
        .done_o     (done),
        .err_o      (err),
        .execute_o  (execute),
        .read_o     (read),
        .write_o    (write),
        .bus_addr_o (busAddr),
        .bus_dout_o (busDout),
        .busy_i     (busy),
        .load_i     (load),
        .bus_din_i  (busDin)
    );

    int checks = 0;
    int errors = 0;

    // Single comparison point: counts every check, reports any disagreement
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bus cycles are recorded as {isWrite, address, writeData}
    logic [39:0] obsQ[$];
    logic [39:0] expQ[$];
    logic [15:0] srVals[$];
    int          srIdx;
    int          busyCnt;
    int          busyLen;
    int          doneCnt;
    int          rdVldCnt;
    bit          noBusy;
    bit          curPoll;
    bit          doneErr;
    logic [15:0] rdValue;
    logic [15:0] pendData;
    time         execTime;
    time         doneTime;
    bit          expErr;
    logic [15:0] expStatus;
    logic [15:0] expRd;

    // Interface FSM model: BUSY rises right after EXECUTE, LOAD on the last busy cycle
    always @(negedge clk) begin
        if (!rstN) begin
            busy    = 1'b0;
            load    = 1'b0;
            busDin  = '0;
            busyCnt = 0;
        end else begin
            if (execute) begin
                checkOutput("execWhileBusy", 64'(busy), 64'd0);
                checkOutput("readWriteExcl", 64'(read ^ write), 64'd1);
                obsQ.push_back({write, busAddr, write ? busDout : 16'h0000});
                execTime = $time;
                if (curPoll && read) begin
                    pendData = (srIdx < srVals.size()) ? srVals[srIdx] : 16'h0000;
                    srIdx++;
                end else begin
                    pendData = rdValue;
                end
            end
            if (busyCnt > 0) begin
                busyCnt--;
                if (busyCnt == 1) begin
                    load   = 1'b1;
                    busDin = pendData;
                end else if (busyCnt == 0) begin
                    busy   = 1'b0;
                    load   = 1'b0;
                    busDin = '0;
                end
            end else if (execute && !noBusy) begin
                busy    = 1'b1;
                busyCnt = (busyLen != 0) ? busyLen : int'($urandom_range(3, 5));
            end
            if (done) begin
                doneCnt++;
                doneErr  = err;
                doneTime = $time;
            end
            if (rdVld) begin
                rdVldCnt++;
            end
        end
    end

    // Expected bus cycles and results from the command step rules
    task automatic buildExpected(input logic [2:0] op, input logic [22:0] addr, input logic [15:0] data);
        logic [15:0] sr;
        logic [15:0] savedStatus;
        logic [15:0] savedRd;
        bit ready;
        savedStatus = expStatus;
        savedRd     = expRd;
        expQ.delete();
        expErr = 1'b0;
        case (op)
            OP_READ: begin
                expQ.push_back({1'b0, addr, 16'h0000});
                expRd = rdValue;
            end
            OP_WRITE: expQ.push_back({1'b1, addr, data});
            OP_UNLOCK: begin
                expQ.push_back({1'b1, addr, 16'h0060});
                expQ.push_back({1'b1, addr, 16'h00D0});
            end
            OP_PROG, OP_ERASE: begin
                expQ.push_back({1'b1, addr, (op == OP_PROG) ? 16'h0040 : 16'h0020});
                expQ.push_back({1'b1, addr, (op == OP_PROG) ? data : 16'h00D0});
                expQ.push_back({1'b1, addr, 16'h0070});
                ready = 1'b0;
                for (int i = 0; i < POLL_MAX && !ready; i++) begin
                    sr = (i < srVals.size()) ? srVals[i] : 16'h0000;
                    expQ.push_back({1'b0, addr, 16'h0000});
                    expStatus = sr;
                    if (sr[7]) ready = 1'b1;
                end
                if (ready) begin
                    expErr = |(expStatus & 16'h003A);
                    expQ.push_back({1'b1, addr, 16'h00FF});
                end else begin
                    expErr = 1'b1;
                end
            end
            default: expErr = 1'b1;
        endcase
        // A bus that never answers stops the command after its first cycle
        if (noBusy && expQ.size() > 0) begin
            while (expQ.size() > 1) void'(expQ.pop_back());
            expErr    = 1'b1;
            expStatus = savedStatus;
            expRd     = savedRd;
        end
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [22:0] addr, input logic [15:0] data);
        int t = 0;
        while (!cmdRdy && t < 100) begin
            @(negedge clk);
            t++;
        end
        checkOutput("cmdRdyWait", 64'(cmdRdy), 64'd1);
        cmdVld  = 1'b1;
        cmdOp   = op;
        cmdAddr = addr;
        cmdData = data;
        @(negedge clk);
        cmdVld = 1'b0;
    endtask

    task automatic runCommand(input logic [2:0] op, input logic [22:0] addr, input logic [15:0] data);
        int t = 0;
        int n;
        buildExpected(op, addr, data);
        obsQ.delete();
        doneCnt  = 0;
        rdVldCnt = 0;
        srIdx    = 0;
        curPoll  = (op == OP_PROG) || (op == OP_ERASE);
        applyStimulus(op, addr, data);
        if (op > OP_UNLOCK) begin
            checkOutput("illegalDoneNext", 64'({done, err}), 64'd3);
        end
        while (doneCnt == 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        checkOutput("doneCount", 64'(doneCnt), 64'd1);
        checkOutput("numCycles", 64'(obsQ.size()), 64'(expQ.size()));
        n = (obsQ.size() < expQ.size()) ? obsQ.size() : expQ.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("cycle%0d", i), 64'(obsQ[i]), 64'(expQ[i]));
        end
        checkOutput("doneErr", 64'(doneErr), 64'(expErr));
        checkOutput("status", 64'(status), 64'(expStatus));
        checkOutput("rdData", 64'(rdData), 64'(expRd));
        checkOutput("rdVldCount", 64'(rdVldCnt), (op == OP_READ && !noBusy) ? 64'd1 : 64'd0);
        if (noBusy) begin
            checkOutput("busyTimeoutLat", 64'((doneTime - execTime) / 10), 64'(BUSY_TO + 1));
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "Ctrl"}, 64'({cmdRdy, execute, read, write, done, err, rdVld}), 64'h40);
        checkOutput({tag, "RdData"}, 64'(rdData), 64'd0);
        checkOutput({tag, "Status"}, 64'(status), 64'd0);
        checkOutput({tag, "BusAddr"}, 64'(busAddr), 64'd0);
        checkOutput({tag, "BusDout"}, 64'(busDout), 64'd0);
    endtask

    initial begin
        int t;
        int pick;
        int nNot;
        logic [2:0] op;
        rstN      = 1'b0;
        cmdVld    = 1'b0;
        cmdOp     = '0;
        cmdAddr   = '0;
        cmdData   = '0;
        busy      = 1'b0;
        load      = 1'b0;
        busDin    = '0;
        noBusy    = 1'b0;
        busyLen   = 0;
        rdValue   = '0;
        expStatus = '0;
        expRd     = '0;
        curPoll   = 1'b0;

        repeat (3) @(negedge clk);
        checkResetState("rst");
        rstN = 1'b1;
        @(negedge clk);

        // Directed commands
        rdValue = 16'hBEEF;
        srVals.delete();
        runCommand(OP_READ, 23'h000123, 16'h0000);
        srVals = '{16'h0000, 16'h0000, 16'h0000, 16'h0080};
        runCommand(OP_PROG, 23'h001000, 16'h5A5A);
        srVals = '{16'h0000, 16'h00A0};
        runCommand(OP_ERASE, 23'h0ABCDE, 16'h1234);
        srVals.delete();
        runCommand(OP_PROG, 23'h7FFFFF, 16'hFFFF);
        runCommand(OP_UNLOCK, 23'h000040, 16'h0000);
        runCommand(OP_WRITE, 23'h000007, 16'hA5C3);
        runCommand(3'd6, 23'h000321, 16'h0000);

        // Bus that never raises BUSY
        noBusy = 1'b1;
        runCommand(OP_WRITE, 23'h000456, 16'h0F0F);
        noBusy = 1'b0;

        // Asynchronous reset in the middle of a PROG
        busyLen = 5;
        srVals.delete();
        obsQ.delete();
        doneCnt = 0;
        srIdx   = 0;
        curPoll = 1'b1;
        applyStimulus(OP_PROG, 23'h002222, 16'hC3C3);
        t = 0;
        while (obsQ.size() < 2 && t < 200) begin
            @(negedge clk);
            t++;
        end
        checkOutput("midCmdCycles", 64'(obsQ.size()), 64'd2);
        repeat (2) @(negedge clk);
        #2 rstN = 1'b0;
        #1 checkResetState("asyncRst");
        busy    = 1'b0;
        load    = 1'b0;
        busDin  = '0;
        busyCnt = 0;
        @(negedge clk);
        rstN    = 1'b1;
        busyLen = 0;
        repeat (4) @(negedge clk);
        checkOutput("noDoneAfterAbort", 64'(doneCnt), 64'd0);
        expStatus = '0;
        expRd     = '0;
        rdValue   = 16'h1357;
        runCommand(OP_READ, 23'h000ACE, 16'h0000);

        // Random commands
        for (int i = 0; i < 30; i++) begin
            pick = int'($urandom_range(0, 11));
            op   = (pick < 10) ? 3'(pick % 5) : 3'(5 + $urandom_range(0, 2));
            rdValue = 16'($urandom);
            nNot = int'($urandom_range(0, POLL_MAX + 1));
            srVals.delete();
            for (int k = 0; k < nNot; k++) begin
                srVals.push_back(16'($urandom) & 16'hFF7F);
            end
            srVals.push_back(16'h0080 | (($urandom_range(0, 2) == 0) ? (16'($urandom) & 16'h003A) : 16'h0000));
            runCommand(op, 23'($urandom), 16'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
